// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline constants for the hazard controller: icodes, status codes, RNONE.
// Helper functions classify status and memory-touching instructions.
package pipe_ctrl_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  function automatic logic is_exc(input logic [3:0] stat);
    return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

  function automatic logic is_mem_icode(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_MRMOVQ) || (icode == I_CALL) ||
           (icode == I_RET)    || (icode == I_PUSHQ)  || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-to-controller bundle: stage icodes/register IDs/status in, stall/bubble controls out.
// The pipeline side is the master; the hazard controller is the slave.
interface pipe_ctrl_if;
  logic [3:0] D_icode_i;
  logic [3:0] E_icode_i;
  logic [3:0] M_icode_i;
  logic [3:0] d_srcA_i;
  logic [3:0] d_srcB_i;
  logic [3:0] E_dstM_i;
  logic       e_Cnd_i;
  logic [3:0] m_stat_i;
  logic [3:0] W_stat_i;
  logic       dmem_ack_i;
  logic       dmem_req_o;
  logic       F_stall_o;
  logic       D_stall_o;
  logic       E_stall_o;
  logic       M_stall_o;
  logic       W_stall_o;
  logic       D_bubble_o;
  logic       E_bubble_o;
  logic       M_bubble_o;
  logic       set_cc_o;

  modport master (
    output D_icode_i, E_icode_i, M_icode_i, d_srcA_i, d_srcB_i, E_dstM_i,
           e_Cnd_i, m_stat_i, W_stat_i, dmem_ack_i,
    input  dmem_req_o, F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
           D_bubble_o, E_bubble_o, M_bubble_o, set_cc_o
  );

  modport slave (
    input  D_icode_i, E_icode_i, M_icode_i, d_srcA_i, d_srcB_i, E_dstM_i,
           e_Cnd_i, m_stat_i, W_stat_i, dmem_ack_i,
    output dmem_req_o, F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
           D_bubble_o, E_bubble_o, M_bubble_o, set_cc_o
  );
endinterface

// File: rtl/pipe_ctrl_sat_cnt32.sv
// 32-bit enabled up-counter that sticks at all-ones instead of wrapping.
module sat_cnt32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);
  logic [31:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else if (en_i && (cnt_q != 32'hFFFF_FFFF))
      cnt_q <= cnt_q + 32'd1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use/ret/mispredict handling, memory-wait freeze, halt on W exception.
//   state      | meaning
//   ST_RUN     | normal flow, hazard stalls/bubbles decoded from stage contents
//   ST_MEMWAIT | M-stage access outstanding, whole pipe frozen until dmem_ack_i
//   ST_HALTED  | exception retired in W, pipe frozen until reset
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  pipe_ctrl_if.slave    pif,
  output logic          halted_o,
  output logic [31:0]   stall_cnt_o,
  output logic [31:0]   cyc_cnt_o
);
  typedef enum logic [1:0] {ST_RUN, ST_MEMWAIT, ST_HALTED} state_t;

  state_t state_q;
  logic   loaduse, ret, mispred, exc_m, exc_w, mem_req;
  logic   f_stall, d_stall, e_stall, m_stall, w_stall;
  logic   d_bubble, e_bubble, m_bubble, set_cc;

  assign loaduse = ((pif.E_icode_i == I_MRMOVQ) || (pif.E_icode_i == I_POPQ)) &&
                   (pif.E_dstM_i != RNONE) &&
                   ((pif.E_dstM_i == pif.d_srcA_i) || (pif.E_dstM_i == pif.d_srcB_i));
  assign ret     = (pif.D_icode_i == I_RET) || (pif.E_icode_i == I_RET) ||
                   (pif.M_icode_i == I_RET);
  assign mispred = (pif.E_icode_i == I_JXX) && !pif.e_Cnd_i;
  assign exc_m   = is_exc(pif.m_stat_i);
  assign exc_w   = is_exc(pif.W_stat_i);
  assign mem_req = (state_q != ST_HALTED) && !exc_m && is_mem_icode(pif.M_icode_i);

  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    e_stall  = 1'b0;
    m_stall  = 1'b0;
    w_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    set_cc   = 1'b0;
    case (state_q)
      ST_RUN: begin
        f_stall  = loaduse | ret;
        d_stall  = loaduse;
        d_bubble = mispred | (ret & !loaduse);
        e_bubble = mispred | loaduse;
        m_bubble = exc_m | exc_w;
        w_stall  = exc_w;
        set_cc   = (pif.E_icode_i == I_OPQ) & !exc_m & !exc_w;
      end
      default: begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        e_stall = 1'b1;
        m_stall = 1'b1;
        w_stall = 1'b1;
      end
    endcase
  end

  // Halt wins over a concurrent memory stall; excW is not looked at while frozen in MEMWAIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      halted_o <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (exc_w) begin
            state_q  <= ST_HALTED;
            halted_o <= 1'b1;
          end else if (mem_req && !pif.dmem_ack_i) begin
            state_q <= ST_MEMWAIT;
          end
        end
        ST_MEMWAIT: if (pif.dmem_ack_i) state_q <= ST_RUN;
        default:    state_q <= ST_HALTED;
      endcase
    end
  end

  assign pif.dmem_req_o = mem_req;
  assign pif.F_stall_o  = f_stall;
  assign pif.D_stall_o  = d_stall;
  assign pif.E_stall_o  = e_stall;
  assign pif.M_stall_o  = m_stall;
  assign pif.W_stall_o  = w_stall;
  assign pif.D_bubble_o = d_bubble;
  assign pif.E_bubble_o = e_bubble;
  assign pif.M_bubble_o = m_bubble;
  assign pif.set_cc_o   = set_cc;

  sat_cnt32 u_cyc_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (state_q != ST_HALTED),
    .cnt_o (cyc_cnt_o)
  );

  sat_cnt32 u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  ((state_q != ST_HALTED) && f_stall),
    .cnt_o (stall_cnt_o)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors go through a scoreboard queue,
// counters are tracked by an independent saturating model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        halted;
  logic [31:0] stall_cnt, cyc_cnt;

  pipe_ctrl_if ifc ();

  pipe_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pif         (ifc),
    .halted_o    (halted),
    .stall_cnt_o (stall_cnt),
    .cyc_cnt_o   (cyc_cnt)
  );

  always #5 clk_i = ~clk_i;

  // {F,D,E,M,W stall | D,E,M bubble | set_cc | dmem_req | halted}
  localparam logic [10:0] V_ZERO   = 11'b00000_000_0_0_0;
  localparam logic [10:0] V_LU     = 11'b11000_010_0_0_0;
  localparam logic [10:0] V_MISP   = 11'b00000_110_0_0_0;
  localparam logic [10:0] V_MISPR  = 11'b10000_110_0_0_0;
  localparam logic [10:0] V_OPQ    = 11'b00000_000_1_0_0;
  localparam logic [10:0] V_EXCM   = 11'b00000_001_0_0_0;
  localparam logic [10:0] V_REQ    = 11'b00000_000_0_1_0;
  localparam logic [10:0] V_WAIT   = 11'b11111_000_0_1_0;
  localparam logic [10:0] V_HALTW  = 11'b00001_001_0_1_0;
  localparam logic [10:0] V_HALTED = 11'b11111_000_0_0_1;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_t;

  sb_t         sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cyc  = '0;
  logic [31:0] exp_stall = '0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic idle();
    ifc.D_icode_i  = I_NOP;
    ifc.E_icode_i  = I_NOP;
    ifc.M_icode_i  = I_NOP;
    ifc.d_srcA_i   = RNONE;
    ifc.d_srcB_i   = RNONE;
    ifc.E_dstM_i   = RNONE;
    ifc.e_Cnd_i    = 1'b1;
    ifc.m_stat_i   = S_AOK;
    ifc.W_stat_i   = S_AOK;
    ifc.dmem_ack_i = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [10:0] exp);
    sb_t         e;
    logic [10:0] got;
    sb.push_back('{tag, exp});
    #1;
    got = {ifc.F_stall_o, ifc.D_stall_o, ifc.E_stall_o, ifc.M_stall_o, ifc.W_stall_o,
           ifc.D_bubble_o, ifc.E_bubble_o, ifc.M_bubble_o, ifc.set_cc_o, ifc.dmem_req_o,
           halted};
    e = sb.pop_front();
    n_assert++;
    assert (got === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", e.tag, got, e.exp);
      end
  endtask

  task automatic check_cnt(input string tag);
    n_assert++;
    assert (cyc_cnt === exp_cyc)
      else begin
        n_fail++;
        $error("FAIL %s cyc_cnt: observed %h expected %h", tag, cyc_cnt, exp_cyc);
      end
    n_assert++;
    assert (stall_cnt === exp_stall)
      else begin
        n_fail++;
        $error("FAIL %s stall_cnt: observed %h expected %h", tag, stall_cnt, exp_stall);
      end
  endtask

  // One clock cycle: check outputs just after the driving negedge, account the cycle, move on.
  task automatic step(input string tag, input logic [10:0] exp);
    check_out(tag, exp);
    if (!exp[0]) begin
      exp_cyc = sat_inc(exp_cyc);
      if (exp[10]) exp_stall = sat_inc(exp_stall);
    end
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    check_out("reset_outputs", V_ZERO);
    check_cnt("reset_counters");
    @(negedge clk_i);
    rst_i = 1'b0;

    step("idle", V_ZERO);

    idle(); ifc.E_icode_i = I_MRMOVQ; ifc.E_dstM_i = 4'h3; ifc.d_srcA_i = 4'h3;
    step("loaduse_srcA", V_LU);
    check_cnt("after_loaduse");

    idle(); ifc.E_icode_i = I_POPQ; ifc.E_dstM_i = 4'h6; ifc.d_srcB_i = 4'h6;
    step("loaduse_popq_srcB", V_LU);

    idle(); ifc.E_icode_i = I_MRMOVQ;
    step("dstM_rnone", V_ZERO);

    idle(); ifc.E_icode_i = I_JXX; ifc.e_Cnd_i = 1'b0;
    step("mispredict", V_MISP);

    idle(); ifc.E_icode_i = I_JXX; ifc.e_Cnd_i = 1'b0; ifc.D_icode_i = I_RET;
    step("mispredict_ret", V_MISPR);

    idle(); ifc.E_icode_i = I_MRMOVQ; ifc.E_dstM_i = 4'h3; ifc.d_srcA_i = 4'h3;
    ifc.D_icode_i = I_RET;
    step("loaduse_ret", V_LU);

    idle(); ifc.E_icode_i = I_OPQ;
    step("opq_setcc", V_OPQ);

    idle(); ifc.E_icode_i = I_OPQ; ifc.m_stat_i = S_ADR;
    step("opq_excm", V_EXCM);
    check_cnt("after_hazards");

    idle(); ifc.M_icode_i = I_MRMOVQ; ifc.dmem_ack_i = 1'b1;
    step("mem_ack_same_cycle", V_REQ);
    idle();
    step("no_stall_after_ack", V_ZERO);

    idle(); ifc.M_icode_i = I_MRMOVQ;
    step("mem_req_no_ack", V_REQ);
    ifc.W_stat_i = S_HLT;
    step("memwait_1_excw_ignored", V_WAIT);
    step("memwait_2_excw_ignored", V_WAIT);
    ifc.W_stat_i = S_AOK; ifc.dmem_ack_i = 1'b1;
    step("memwait_3_ack", V_WAIT);
    idle();
    step("run_after_ack", V_ZERO);
    check_cnt("after_memwait");

    idle(); ifc.W_stat_i = S_HLT; ifc.E_icode_i = I_OPQ; ifc.M_icode_i = I_MRMOVQ;
    step("halt_edge", V_HALTW);
    idle(); ifc.E_icode_i = I_OPQ; ifc.M_icode_i = I_MRMOVQ;
    step("halted_1", V_HALTED);
    idle(); ifc.dmem_ack_i = 1'b1;
    step("halted_2", V_HALTED);
    check_cnt("frozen_in_halt");

    idle();
    rst_i = 1'b1;
    check_out("reset_from_halt", V_ZERO);
    exp_cyc = '0; exp_stall = '0;
    check_cnt("reset_from_halt");
    rst_i = 1'b0;
    exp_cyc = sat_inc(exp_cyc);
    @(negedge clk_i);

    idle(); ifc.M_icode_i = I_MRMOVQ;
    step("req_before_rst", V_REQ);
    step("memwait_before_rst", V_WAIT);
    rst_i = 1'b1;
    check_out("rst_mid_memwait", V_REQ);
    exp_cyc = '0; exp_stall = '0;
    check_cnt("rst_mid_memwait");
    ifc.M_icode_i = I_NOP;
    rst_i = 1'b0;
    exp_cyc = sat_inc(exp_cyc);
    @(negedge clk_i);
    step("run_after_rst", V_ZERO);
    check_cnt("after_rst_release");

    dut.u_cyc_cnt.cnt_q   = 32'hFFFF_FFFE;
    dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
    exp_cyc   = 32'hFFFF_FFFE;
    exp_stall = 32'hFFFF_FFFE;
    idle(); ifc.E_icode_i = I_MRMOVQ; ifc.E_dstM_i = 4'h3; ifc.d_srcA_i = 4'h3;
    for (int i = 0; i < 3; i++) step("sat_stall", V_LU);
    check_cnt("saturation");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected end of sequence");
    $fatal(1, "watchdog expired");
  end
endmodule
